// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin scheduler that lends one shared WIDTH-bit
// up-counter to NREQ requesters, one timed interval at a time.
module counter_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   len,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic [WIDTH-1:0]        cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    ptr, ptr_nxt;
  logic [IW-1:0]    win_idx, win_nxt;
  logic [IW-1:0]    pick;
  logic [WIDTH-1:0] len_q, len_nxt;
  logic [WIDTH-1:0] cnt_nxt;

  // Next round-robin position after index i, wrapping at NREQ-1.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    if (int'(i) == NREQ - 1)
      return '0;
    else
      return i + 1'b1;
  endfunction

  // Round-robin pick: first active requester at or above ptr, modulo NREQ.
  // Scanning from the far end lets the closest hit overwrite earlier ones.
  always_comb begin
    int t;
    t    = 0;
    pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      t = int'(ptr) + k;
      if (t >= NREQ)
        t = t - NREQ;
      if (req[t])
        pick = IW'(t);
    end
  end

  // Next-state logic; abort outranks the terminal-count check in RUN.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    win_nxt   = win_idx;
    len_nxt   = len_q;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (|req) begin
          win_nxt   = pick;
          len_nxt   = len[int'(pick)*WIDTH +: WIDTH];
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!req[win_idx]) begin
          ptr_nxt   = wrap_inc(win_idx);
          state_nxt = IDLE;
        end else if (cnt == len_q) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        ptr_nxt   = wrap_inc(win_idx);
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, pointer, winner, latched length and shared counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      win_idx <= '0;
      len_q   <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      win_idx <= win_nxt;
      len_q   <= len_nxt;
      cnt     <= cnt_nxt;
    end
  end

  // Outputs decode registered state only, so req never reaches gnt/done
  // through combinational logic.
  always_comb begin
    gnt  = '0;
    done = '0;
    busy = (state != IDLE);
    if (state == RUN)
      gnt[win_idx] = 1'b1;
    if (state == DONE)
      done[win_idx] = 1'b1;
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Self-checking bench for counter_arbiter (NREQ=4, WIDTH=5).
module tb_counter_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [19:0] len;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [4:0]  cnt;

  int n_checks;
  int n_fail;

  counter_arbiter #(.NREQ(4), .WIDTH(5)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .len  (len),
    .gnt  (gnt),
    .done (done),
    .busy (busy),
    .cnt  (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [19:0] len;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [4:0]  cnt;
    logic [1:0]  ptr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [19:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {5'(l3), 5'(l2), 5'(l1), 5'(l0)};
  endfunction

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [19:0] ln,
                              input logic [3:0] g, input logic [3:0] d, input logic b,
                              input int c, input int p);
    vec_t v;
    v.rst = r; v.req = rq; v.len = ln;
    v.gnt = g; v.done = d; v.busy = b; v.cnt = 5'(c); v.ptr = 2'(p);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs away from the edge, then sample just after the edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic [19:0] ln);
    @(negedge clk);
    rst = r; req = rq; len = ln;
    @(posedge clk);
    #1;
  endtask

  // done must never have more than one bit set.
  always @(negedge clk) begin
    if (done != 4'b0) begin
      n_checks++;
      if ($countones(done) > 1) begin
        n_fail++;
        $display("FAIL done_onehot: got %b expected at most one bit", done);
      end
    end
  end

  // Watchdog so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req = '0; len = '0;
    n_checks = 0; n_fail = 0;

    // Single job, len0=3: gnt cycles 1-4, done cycle 5, ptr -> 1.
    vecs.push_back(mk(1, 4'b0000, pk(3,0,0,0), 4'b0000, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0001, pk(3,0,0,0), 4'b0001, 4'b0000, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0001, pk(3,0,0,0), 4'b0001, 4'b0000, 1, 1, 0));
    vecs.push_back(mk(0, 4'b0001, pk(3,0,0,0), 4'b0001, 4'b0000, 1, 2, 0));
    vecs.push_back(mk(0, 4'b0001, pk(3,0,0,0), 4'b0001, 4'b0000, 1, 3, 0));
    vecs.push_back(mk(0, 4'b0001, pk(3,0,0,0), 4'b0000, 4'b0001, 1, 3, 0));
    vecs.push_back(mk(0, 4'b0000, pk(3,0,0,0), 4'b0000, 4'b0000, 0, 3, 1));
    // All four requesting with len=0: grants 0,1,2,3, one done every 3 cycles.
    vecs.push_back(mk(1, 4'b0000, pk(0,0,0,0), 4'b0000, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b1111, pk(0,0,0,0), 4'b0001, 4'b0000, 1, 0, 0));
    vecs.push_back(mk(0, 4'b1111, pk(0,0,0,0), 4'b0000, 4'b0001, 1, 0, 0));
    vecs.push_back(mk(0, 4'b1110, pk(0,0,0,0), 4'b0000, 4'b0000, 0, 0, 1));
    vecs.push_back(mk(0, 4'b1110, pk(0,0,0,0), 4'b0010, 4'b0000, 1, 0, 1));
    vecs.push_back(mk(0, 4'b1110, pk(0,0,0,0), 4'b0000, 4'b0010, 1, 0, 1));
    vecs.push_back(mk(0, 4'b1100, pk(0,0,0,0), 4'b0000, 4'b0000, 0, 0, 2));
    vecs.push_back(mk(0, 4'b1100, pk(0,0,0,0), 4'b0100, 4'b0000, 1, 0, 2));
    vecs.push_back(mk(0, 4'b1100, pk(0,0,0,0), 4'b0000, 4'b0100, 1, 0, 2));
    vecs.push_back(mk(0, 4'b1000, pk(0,0,0,0), 4'b0000, 4'b0000, 0, 0, 3));
    vecs.push_back(mk(0, 4'b1000, pk(0,0,0,0), 4'b1000, 4'b0000, 1, 0, 3));
    vecs.push_back(mk(0, 4'b1000, pk(0,0,0,0), 4'b0000, 4'b1000, 1, 0, 3));
    vecs.push_back(mk(0, 4'b0000, pk(0,0,0,0), 4'b0000, 4'b0000, 0, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].len);
      check($sformatf("vec%0d_gnt", i),  32'(gnt),     32'(vecs[i].gnt));
      check($sformatf("vec%0d_done", i), 32'(done),    32'(vecs[i].done));
      check($sformatf("vec%0d_busy", i), 32'(busy),    32'(vecs[i].busy));
      check($sformatf("vec%0d_cnt", i),  32'(cnt),     32'(vecs[i].cnt));
      check($sformatf("vec%0d_ptr", i),  32'(dut.ptr), 32'(vecs[i].ptr));
    end

    // Full-scale length 31: counts to 31 without wrap, done in cycle 33.
    step(1, 4'b0000, pk(0,0,0,0));
    for (int k = 1; k <= 32; k++) begin
      step(0, 4'b0001, pk(31,0,0,0));
      check($sformatf("max_cnt_c%0d", k), 32'(cnt), 32'(k - 1));
      check($sformatf("max_gnt_c%0d", k), 32'(gnt), 32'(4'b0001));
    end
    step(0, 4'b0001, pk(31,0,0,0));
    check("max_done_c33", 32'(done), 32'(4'b0001));
    check("max_cnt_c33",  32'(cnt),  32'd31);
    step(0, 4'b0000, pk(31,0,0,0));
    check("max_idle_busy", 32'(busy), 32'd0);

    // Abort: req1 dropped while cnt=2 with len1=6.
    step(1, 4'b0000, pk(0,0,0,0));
    step(0, 4'b0010, pk(0,6,0,0));
    check("abort_gnt_c1", 32'(gnt), 32'(4'b0010));
    step(0, 4'b0010, pk(0,6,0,0));
    step(0, 4'b0010, pk(0,6,0,0));
    check("abort_cnt_c3", 32'(cnt), 32'd2);
    step(0, 4'b0000, pk(0,6,0,0));
    check("abort_gnt",  32'(gnt),     32'd0);
    check("abort_done", 32'(done),    32'd0);
    check("abort_busy", 32'(busy),    32'd0);
    check("abort_cnt",  32'(cnt),     32'd2);
    check("abort_ptr",  32'(dut.ptr), 32'd2);
    step(0, 4'b0000, pk(0,6,0,0));
    check("abort_nodone", 32'(done), 32'd0);

    // Reset during RUN with cnt=4 (requester 2, ptr currently 2).
    step(0, 4'b0100, pk(0,0,10,0));
    check("rstrun_gnt", 32'(gnt), 32'(4'b0100));
    for (int k = 0; k < 4; k++) step(0, 4'b0100, pk(0,0,10,0));
    check("rstrun_cnt4", 32'(cnt), 32'd4);
    step(1, 4'b0100, pk(0,0,10,0));
    check("rstrun_gnt0",  32'(gnt),     32'd0);
    check("rstrun_cnt0",  32'(cnt),     32'd0);
    check("rstrun_busy0", 32'(busy),    32'd0);
    check("rstrun_done0", 32'(done),    32'd0);
    check("rstrun_ptr0",  32'(dut.ptr), 32'd0);

    // req0 held through its done while req2 waits: next grant is 2.
    step(1, 4'b0000, pk(0,0,0,0));
    step(0, 4'b0101, pk(1,0,1,0));
    check("rr_gnt0", 32'(gnt), 32'(4'b0001));
    step(0, 4'b0101, pk(1,0,1,0));
    step(0, 4'b0101, pk(1,0,1,0));
    check("rr_done0", 32'(done), 32'(4'b0001));
    step(0, 4'b0101, pk(1,0,1,0));
    check("rr_idle", 32'(busy), 32'd0);
    step(0, 4'b0101, pk(1,0,1,0));
    check("rr_gnt2", 32'(gnt), 32'(4'b0100));

    // len0 changed from 2 to 9 mid-RUN: done still at cnt=2.
    step(1, 4'b0000, pk(0,0,0,0));
    step(0, 4'b0001, pk(2,0,0,0));
    step(0, 4'b0001, pk(9,0,0,0));
    step(0, 4'b0001, pk(9,0,0,0));
    check("lenchg_cnt2", 32'(cnt), 32'd2);
    step(0, 4'b0001, pk(9,0,0,0));
    check("lenchg_done", 32'(done), 32'(4'b0001));
    check("lenchg_cnt",  32'(cnt),  32'd2);
    step(0, 4'b0000, pk(9,0,0,0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Round-robin scheduler that shares a single WIDTH-bit up-counter between NREQ requesters. Each requester asks for a timed interval of a given length. The block grants one requester at a time, clears and runs the shared counter until it reaches the granted length, then pulses that requester's done. It sits between the client blocks and the counter datapath and owns every clear and increment of the count.

## Interface
- NREQ, 4, number of requesters; legal range 2..8.
- WIDTH, 5, counter and length width in bits.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  NREQ  per-requester request level; must be held high until that requester's done.
- len  input  NREQ*WIDTH  per-requester terminal count; requester i occupies bits len[i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant; high for the whole RUN phase of the granted job.
- done  output  NREQ  one-hot, single-cycle completion pulse.
- busy  output  1  high in every state except IDLE.
- cnt  output  WIDTH  shared counter value.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE
  - If req is nonzero, the arbiter selects a winner round-robin, starting at pointer ptr and searching upward modulo NREQ.
  - It latches win_idx and len_q (the winner's len field), clears cnt to 0 and moves to RUN.
  - If req is zero, the FSM stays in IDLE and cnt holds.
- RUN
  - gnt[win_idx] is high.
  - If cnt == len_q, cnt holds and the FSM moves to DONE.
  - Otherwise cnt increments by 1.
- DONE
  - done[win_idx] is high for exactly this cycle and gnt is low.
  - ptr is set to (win_idx+1) mod NREQ, and the FSM returns to IDLE.
- Abort
  - If req[win_idx] is low during any RUN cycle, the job is aborted.
  - The FSM returns directly to IDLE, with no done pulse and gnt low on the next cycle.
  - ptr advances as for a completed job, and cnt holds its value.
  - The abort check takes priority over the terminal-count check.
- len_q is captured only at grant. Changes to len during RUN are ignored.
- cnt never exceeds len_q ≤ 2^WIDTH−1, so cnt never wraps.
- The req and len of requesters that are not granted have no effect during RUN or DONE.
- Requesters deassert req in the cycle after they sample done.
  - If req is still high in the IDLE cycle after DONE, it counts as a new request.
  - That new request loses to any other active requester, because ptr has moved past it.

## Timing
- Reset values: state=IDLE, gnt=0, done=0, busy=0, cnt=0, ptr=0, win_idx=0, len_q=0.
- rst asserted in any state, including mid-RUN or in DONE: all outputs take their reset values on the next edge, and no done pulse is produced.
- Latency for a job of length L, with req sampled high in the IDLE cycle numbered 0:
  - cycle 1: gnt high, cnt=0.
  - cycle 1+L: cnt=L.
  - cycle 2+L: done pulse.
  - cycle 3+L: back in IDLE.
- Occupancy is L+3 cycles per job. Back-to-back grants are separated by one IDLE cycle.
- L=0: a single RUN cycle with cnt=0, then done in cycle 2.
- busy is high from cycle 1 through cycle 2+L.
- Simultaneous requests resolve in a single IDLE cycle. There are no combinational paths from req to gnt or done; both are registered.

## Test plan
- Reset, then req=4'b0001 with len0=3.
  - Required: gnt=0001 in cycles 1–4; cnt=0,1,2,3; done=0001 in cycle 5 only.
  - Required: ptr=1 afterwards, and a 5-cycle busy window in total.
- All four req high, every len=0, each requester dropping req after its done.
  - Required: grants in order 0,1,2,3; one done each, every 3 cycles.
  - Required: done never has more than one bit set.
- len0=31 (WIDTH=5).
  - Required: cnt reaches 31 without wrap and done is seen in cycle 33.
- Abort: req1 dropped when cnt=2 with len1=6.
  - Required: gnt low next cycle, no done, FSM back in IDLE, ptr=2.
- rst pulsed in a RUN cycle with cnt=4.
  - Required: next cycle gnt=0, cnt=0, busy=0, no done; ptr=0.
- req0 held high through done while req2 is also high.
  - Required: the next grant goes to requester 2, not 0.
- len0 changed from 2 to 9 during RUN.
  - Required: done still occurs when cnt=2.
